// File: rtl/dfu_bank_rd_ctrl.sv
// ---------------------------------------------------------------------------
// dfu_bank_rd_ctrl
//
// Read-side sequencer for the DFU ping-pong SRAM bank array. When the writer
// signals that bank A or bank B is full, the tile is read out word by word
// across all SRAM banks of that side in lockstep. The returning read data is
// pushed into a 4-entry output FIFO and handed downstream over valid/ready.
// When every word has left the FIFO, the bank is released back to the writer.
// Banks are always served in strict A, B, A, B order.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   bank_a_full/bank_b_full  1-cycle "bank loaded" strobes from the writer
//   tile_len                 words per bank, sampled with the full strobe
//   dfu2ip_{a,b}_sram_rd_en  per-bank read enables (registered)
//   dfu2ip_{a,b}_sram_rd_addr per-bank read addresses (registered)
//   bank_{a,b}_data/_vld     SRAM read data, 1 cycle after rd_en
//   out_data/out_vld/out_rdy downstream word stream, bank i in slice i
//   bank_{a,b}_release       1-cycle "bank drained" strobes to the writer
//   active_bank              0 = A, 1 = B (bank being read or next in line)
//   busy                     sequencer not idle
//   ovf_err                  sticky: full strobe for an already pending bank
// ---------------------------------------------------------------------------
module dfu_bank_rd_ctrl #(
  parameter int no_of_sram_banks = 8,
  parameter int sram_addr        = 10,
  parameter int Es               = 8,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  bank_a_full,
  input  logic                                  bank_b_full,
  input  logic [sram_addr:0]                    tile_len,
  output logic [no_of_sram_banks-1:0]           dfu2ip_a_sram_rd_en,
  output logic [no_of_sram_banks*sram_addr-1:0] dfu2ip_a_sram_rd_addr,
  output logic [no_of_sram_banks-1:0]           dfu2ip_b_sram_rd_en,
  output logic [no_of_sram_banks*sram_addr-1:0] dfu2ip_b_sram_rd_addr,
  input  logic [no_of_sram_banks*Es-1:0]        bank_a_data,
  input  logic [no_of_sram_banks-1:0]           bank_a_vld,
  input  logic [no_of_sram_banks*Es-1:0]        bank_b_data,
  input  logic [no_of_sram_banks-1:0]           bank_b_vld,
  output logic [no_of_sram_banks*Es-1:0]        out_data,
  output logic                                  out_vld,
  input  logic                                  out_rdy,
  output logic                                  bank_a_release,
  output logic                                  bank_b_release,
  output logic                                  active_bank,
  output logic                                  busy,
  output logic                                  ovf_err
);

  localparam int DW = no_of_sram_banks * Es;
  localparam int LW = sram_addr + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RD, DRAIN, REL} state_t;

  state_t               state_reg, state_next;
  logic                 exp_bank_reg, exp_bank_next;
  logic                 pend_a_reg, pend_a_next;
  logic                 pend_b_reg, pend_b_next;
  logic [LW-1:0]        len_a_reg, len_a_next;
  logic [LW-1:0]        len_b_reg, len_b_next;
  logic                 ovf_reg, ovf_next;
  logic [sram_addr-1:0] addr_cnt_reg, addr_cnt_next;
  logic [LW-1:0]        words_rem_reg, words_rem_next;
  logic [CW-1:0]        credits_reg, credits_next;
  logic                 rd_en_a_reg, rd_en_b_reg;
  logic [sram_addr-1:0] rd_addr_a_reg, rd_addr_b_reg;

  logic [DW-1:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]        count_reg;

  logic                 issue;
  logic [sram_addr-1:0] issue_addr;
  logic                 rel_a, rel_b;
  logic                 exp_pend;
  logic [LW-1:0]        exp_len;
  logic                 push, pop, push_vld;
  logic [DW-1:0]        push_data;

  // The expected bank only toggles on leaving REL, so it is also the bank
  // being read whenever the sequencer is busy.
  assign exp_pend = exp_bank_reg ? pend_b_reg : pend_a_reg;
  assign exp_len  = exp_bank_reg ? len_b_reg  : len_a_reg;

  // -------------------------------------------------------------------------
  // Sequencer. The read of word 0 is issued on the IDLE->RD edge itself so
  // the registered rd_en appears two cycles after the full strobe; the word
  // counters therefore enter RD already advanced past word 0.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    exp_bank_next  = exp_bank_reg;
    addr_cnt_next  = addr_cnt_reg;
    words_rem_next = words_rem_reg;
    issue          = 1'b0;
    issue_addr     = '0;
    rel_a          = 1'b0;
    rel_b          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (exp_pend) begin
          state_next     = RD;
          addr_cnt_next  = '0;
          words_rem_next = exp_len;
          if (exp_len != '0 && credits_reg != '0) begin
            issue          = 1'b1;
            addr_cnt_next  = sram_addr'(1);
            words_rem_next = exp_len - LW'(1);
          end
        end
      end
      RD: begin
        if (words_rem_reg == '0) begin
          state_next = DRAIN;
        end else if (credits_reg != '0) begin
          issue          = 1'b1;
          issue_addr     = addr_cnt_reg;
          addr_cnt_next  = addr_cnt_reg + sram_addr'(1);
          words_rem_next = words_rem_reg - LW'(1);
          if (words_rem_reg == LW'(1)) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        // All credits back means every issued word has left the FIFO.
        if (credits_reg == CRED_MAX) begin
          state_next = REL;
        end
      end
      REL: begin
        rel_a         = ~exp_bank_reg;
        rel_b         = exp_bank_reg;
        exp_bank_next = ~exp_bank_reg;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Pending flags. A release and a new full strobe in the same cycle leave
  // the bank pending with the new length; a strobe for a bank that stays
  // pending is dropped and flagged.
  // -------------------------------------------------------------------------
  always_comb begin
    pend_a_next = pend_a_reg;
    pend_b_next = pend_b_reg;
    len_a_next  = len_a_reg;
    len_b_next  = len_b_reg;
    ovf_next    = ovf_reg;
    if (rel_a) pend_a_next = 1'b0;
    if (rel_b) pend_b_next = 1'b0;
    if (bank_a_full) begin
      if (pend_a_reg && !rel_a) begin
        ovf_next = 1'b1;
      end else begin
        pend_a_next = 1'b1;
        len_a_next  = tile_len;
      end
    end
    if (bank_b_full) begin
      if (pend_b_reg && !rel_b) begin
        ovf_next = 1'b1;
      end else begin
        pend_b_next = 1'b1;
        len_b_next  = tile_len;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FIFO and credit bookkeeping. Credits cap the outstanding reads at the
  // FIFO depth, so a push never finds the FIFO full; the count guard only
  // protects against stray valid strobes.
  // -------------------------------------------------------------------------
  assign push_vld  = exp_bank_reg ? (&bank_b_vld) : (&bank_a_vld);
  assign push_data = exp_bank_reg ? bank_b_data : bank_a_data;
  assign push      = push_vld && (state_reg == RD || state_reg == DRAIN)
                     && (count_reg != CRED_MAX);
  assign pop       = out_vld && out_rdy;

  assign credits_next = credits_reg - CW'(issue) + CW'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      exp_bank_reg  <= 1'b0;
      pend_a_reg    <= 1'b0;
      pend_b_reg    <= 1'b0;
      len_a_reg     <= '0;
      len_b_reg     <= '0;
      ovf_reg       <= 1'b0;
      addr_cnt_reg  <= '0;
      words_rem_reg <= '0;
      credits_reg   <= CRED_MAX;
      rd_en_a_reg   <= 1'b0;
      rd_en_b_reg   <= 1'b0;
      rd_addr_a_reg <= '0;
      rd_addr_b_reg <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      exp_bank_reg  <= exp_bank_next;
      pend_a_reg    <= pend_a_next;
      pend_b_reg    <= pend_b_next;
      len_a_reg     <= len_a_next;
      len_b_reg     <= len_b_next;
      ovf_reg       <= ovf_next;
      addr_cnt_reg  <= addr_cnt_next;
      words_rem_reg <= words_rem_next;
      credits_reg   <= credits_next;
      rd_en_a_reg   <= issue & ~exp_bank_reg;
      rd_en_b_reg   <= issue & exp_bank_reg;
      if (issue && !exp_bank_reg) rd_addr_a_reg <= issue_addr;
      if (issue && exp_bank_reg)  rd_addr_b_reg <= issue_addr;
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg     <= count_reg + CW'(push) - CW'(pop);
    end
  end

  // One register per FIFO entry; cleared on reset so out_data reads 0.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          fifo_mem[gi] <= '0;
        end else if (push && wr_ptr_reg == PW'(gi)) begin
          fifo_mem[gi] <= push_data;
        end
      end
    end
  endgenerate

  // All banks of a side share one address; fan it out per bank.
  generate
    for (genvar gi = 0; gi < no_of_sram_banks; gi++) begin : g_addr
      assign dfu2ip_a_sram_rd_addr[gi*sram_addr +: sram_addr] = rd_addr_a_reg;
      assign dfu2ip_b_sram_rd_addr[gi*sram_addr +: sram_addr] = rd_addr_b_reg;
    end
  endgenerate

  assign dfu2ip_a_sram_rd_en = {no_of_sram_banks{rd_en_a_reg}};
  assign dfu2ip_b_sram_rd_en = {no_of_sram_banks{rd_en_b_reg}};

  assign out_vld        = (count_reg != '0);
  assign out_data       = fifo_mem[rd_ptr_reg];
  assign bank_a_release = rel_a;
  assign bank_b_release = rel_b;
  assign active_bank    = exp_bank_reg;
  assign busy           = (state_reg != IDLE);
  assign ovf_err        = ovf_reg;

endmodule

// File: tb/tb_dfu_bank_rd_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for dfu_bank_rd_ctrl: directed steps plus a randomized ping-pong run.
// A behavioural SRAM returns data one cycle after rd_en; a monitor tracks
// tiles, read addresses, outstanding reads and delivered words at a tile /
// word level against queues filled by the stimulus.
// ---------------------------------------------------------------------------
module tb_dfu_bank_rd_ctrl;
  localparam int NB = 8;
  localparam int AW = 10;
  localparam int ES = 8;
  localparam int DW = NB * ES;

  typedef struct {
    logic bank;
    int   len;
  } tile_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            bank_a_full = 1'b0, bank_b_full = 1'b0;
  logic [AW:0]     tile_len = '0;
  logic [NB-1:0]   rd_en_a, rd_en_b;
  logic [NB*AW-1:0] rd_addr_a, rd_addr_b;
  logic [DW-1:0]   bank_a_data = '0, bank_b_data = '0;
  logic [NB-1:0]   bank_a_vld = '0, bank_b_vld = '0;
  logic [DW-1:0]   out_data;
  logic            out_vld;
  logic            out_rdy = 1'b1;
  logic            bank_a_release, bank_b_release, active_bank, busy, ovf_err;

  logic [ES-1:0]   sram_a [NB][1024];
  logic [ES-1:0]   sram_b [NB][1024];

  tile_t           tile_q[$];
  logic [DW-1:0]   exp_q[$];
  int              issued = 0, popped = 0;
  int              n_cmp = 0, n_bad = 0;
  bit              rand_rdy = 1'b0;

  dfu_bank_rd_ctrl dut (
    .clk(clk), .rst(rst),
    .bank_a_full(bank_a_full), .bank_b_full(bank_b_full), .tile_len(tile_len),
    .dfu2ip_a_sram_rd_en(rd_en_a), .dfu2ip_a_sram_rd_addr(rd_addr_a),
    .dfu2ip_b_sram_rd_en(rd_en_b), .dfu2ip_b_sram_rd_addr(rd_addr_b),
    .bank_a_data(bank_a_data), .bank_a_vld(bank_a_vld),
    .bank_b_data(bank_b_data), .bank_b_vld(bank_b_vld),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .bank_a_release(bank_a_release), .bank_b_release(bank_b_release),
    .active_bank(active_bank), .busy(busy), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: data and valid one cycle after rd_en.
  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      bank_a_vld[i] <= rd_en_a[i];
      bank_b_vld[i] <= rd_en_b[i];
      bank_a_data[i*ES +: ES] <= sram_a[i][rd_addr_a[i*AW +: AW]];
      bank_b_data[i*ES +: ES] <= sram_b[i][rd_addr_b[i*AW +: AW]];
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] all_outs();
    return {rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, out_data, out_vld,
            bank_a_release, bank_b_release, active_bank, busy, ovf_err};
  endfunction

  // Monitor: every read must belong to the front tile, in address order,
  // with at most 4 words in flight; every word must match the scoreboard;
  // a release must close the front tile with all its words delivered.
  always @(negedge clk) begin
    if (rst) begin
      if (|rd_en_a || |rd_en_b) begin
        if (tile_q.size() == 0) begin
          chk("rd_en_unexpected", {rd_en_a, rd_en_b}, '0);
        end else begin
          chk("rd_en_a", rd_en_a, tile_q[0].bank ? 8'h00 : 8'hFF);
          chk("rd_en_b", rd_en_b, tile_q[0].bank ? 8'hFF : 8'h00);
          for (int i = 0; i < NB; i++)
            chk("rd_addr", tile_q[0].bank ? rd_addr_b[i*AW +: AW] : rd_addr_a[i*AW +: AW], issued);
          chk("rd_within_len", issued < tile_q[0].len, 1);
          issued++;
          chk("outstanding_le4", (issued - popped) <= 4, 1);
        end
      end
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", out_vld, 0);
        end else begin
          chk("out_data", out_data, exp_q.pop_front());
          popped++;
        end
      end
      if (bank_a_release || bank_b_release) begin
        if (tile_q.size() == 0) begin
          chk("release_unexpected", {bank_a_release, bank_b_release}, 2'b00);
        end else begin
          chk("release_bank", {bank_a_release, bank_b_release}, tile_q[0].bank ? 2'b01 : 2'b10);
          chk("release_issued", issued, tile_q[0].len);
          chk("release_popped", popped, tile_q[0].len);
          void'(tile_q.pop_front());
          issued = 0;
          popped = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_rdy = ($urandom_range(3, 0) != 0);
  endtask

  function automatic logic [DW-1:0] word_of(input logic bank, input int j);
    logic [DW-1:0] w;
    for (int i = 0; i < NB; i++) w[i*ES +: ES] = bank ? sram_b[i][j] : sram_a[i][j];
    return w;
  endfunction

  task automatic load_tile(input logic bank, input int len);
    for (int j = 0; j < len; j++)
      for (int i = 0; i < NB; i++)
        if (bank) sram_b[i][j] = 8'($urandom);
        else      sram_a[i][j] = 8'($urandom);
    for (int j = 0; j < len; j++) exp_q.push_back(word_of(bank, j));
    tile_q.push_back('{bank: bank, len: len});
  endtask

  task automatic pulse(input logic bank, input int len);
    tile_len = (AW+1)'(len);
    if (bank) bank_b_full = 1'b1; else bank_a_full = 1'b1;
    step();
    bank_a_full = 1'b0;
    bank_b_full = 1'b0;
  endtask

  task automatic wait_rel(input logic bank, input string tag);
    int n = 0;
    while (!(bank ? bank_b_release : bank_a_release) && n < 300) begin
      step();
      n++;
    end
    chk(tag, bank ? bank_b_release : bank_a_release, 1);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   lens[6];
    logic [DW-1:0] snap;

    // Reset state
    repeat (3) step();
    chk("reset_outputs_in_reset", all_outs(), '0);
    rst = 1'b1;
    step();
    chk("reset_outputs_after", all_outs(), '0);

    // T1: single tile, A len 4, timing table relative to the full strobe
    load_tile(0, 4);
    tile_len = 4;
    bank_a_full = 1'b1;                       // cycle 0
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("t1_rd_en_a_c%0d", c), rd_en_a, (c >= 2 && c <= 5) ? 8'hFF : 8'h00);
      if (c >= 2 && c <= 5) chk($sformatf("t1_addr_c%0d", c), rd_addr_a[AW-1:0], c - 2);
      chk($sformatf("t1_out_vld_c%0d", c), out_vld, (c >= 4 && c <= 7));
      chk($sformatf("t1_rel_a_c%0d", c), bank_a_release, (c == 9));
      step();
      bank_a_full = 1'b0;
    end
    chk("t1_active_toggled", active_bank, 1);

    // T2: B len 2; T3: A len 0; T4: B len 1
    load_tile(1, 2); pulse(1, 2); wait_rel(1, "t2_rel_b");
    chk("t2_active", active_bank, 0);
    load_tile(0, 0); pulse(0, 0);
    n = 0;
    while (!bank_a_release && n < 3) begin step(); n++; end
    chk("t3_len0_release", bank_a_release, 1);
    step();
    chk("t3_active_b", active_bank, 1);
    load_tile(1, 1); pulse(1, 1); wait_rel(1, "t4_rel_b");

    // T5: B loaded first while A absent must wait for A
    load_tile(0, 3);
    load_tile(1, 2);
    pulse(1, 2);
    repeat (6) step();
    chk("t5_b_waits_busy", busy, 0);
    chk("t5_b_waits_active", active_bank, 0);
    pulse(0, 3);
    wait_rel(0, "t5_rel_a");
    wait_rel(1, "t5_rel_b");

    // T6: overflow on pending A, then A full coincident with A release
    load_tile(0, 3); pulse(0, 3);
    step(); step();
    chk("t6_no_ovf_yet", ovf_err, 0);
    pulse(0, 7);
    chk("t6_ovf_set", ovf_err, 1);
    load_tile(1, 2); pulse(1, 2);
    n = 0;
    while (!bank_a_release && n < 100) begin step(); n++; end
    chk("t6_rel_a_seen", bank_a_release, 1);
    load_tile(0, 5);
    tile_len = 5;
    bank_a_full = 1'b1;
    step();
    bank_a_full = 1'b0;
    wait_rel(1, "t6_rel_b");
    wait_rel(0, "t6_rel_a_new_len");
    chk("t6_ovf_sticky", ovf_err, 1);

    // T7: backpressure on B len 8 after the second word
    load_tile(1, 8); pulse(1, 8);
    n = 0;
    while (popped < 2 && n < 50) begin step(); n++; end
    out_rdy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_out_vld", out_vld, 1);
      if (k == 0) snap = out_data;
      else chk("bp_hold_data", out_data, snap);
      step();
    end
    chk("bp_issued", issued, 6);
    chk("bp_popped", popped, 2);
    out_rdy = 1'b1;
    wait_rel(1, "t7_rel_b");

    // T8: randomized ping-pong with random consumer stalls
    rand_rdy = 1'b1;
    for (int k = 0; k < 6; k++) lens[k] = $urandom_range(12, 0);
    load_tile(0, lens[0]); pulse(0, lens[0]);
    load_tile(1, lens[1]); pulse(1, lens[1]);
    for (int k = 2; k < 6; k++) begin
      wait_rel(k[0], "t8_rel");
      load_tile(k[0], lens[k]); pulse(k[0], lens[k]);
    end
    wait_rel(0, "t8_rel_last_a");
    wait_rel(1, "t8_rel_last_b");
    rand_rdy = 1'b0;
    out_rdy = 1'b1;

    // T9: asynchronous reset mid-read, then a fresh tile from address 0
    load_tile(0, 8); pulse(0, 8);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rd_en_a[0] && rd_addr_a[AW-1:0] == 2) && n < 40);
    chk("t9_reached_word2", rd_addr_a[AW-1:0], 2);
    #2 rst = 1'b0;
    #1 chk("t9_async_reset_outputs", all_outs(), '0);
    step(); step();
    tile_q.delete();
    exp_q.delete();
    issued = 0;
    popped = 0;
    rst = 1'b1;
    step();
    load_tile(0, 3); pulse(0, 3);
    wait_rel(0, "t9_rel_a_fresh");

    repeat (3) step();
    chk("end_words_left", exp_q.size(), 0);
    chk("end_tiles_left", tile_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
